// File: rtl/mem_refill_arbiter.sv
// Round-robin refill arbiter: grants the shared word-wide memory port to one
// cache requester at a time and streams a full line back to it beat by beat.
module mem_refill_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH,
    localparam int OFF_BITS       = $clog2(WORDS_PER_LINE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [WORD_WIDTH-1:0]         rsp_data_o,
    output logic [OFF_BITS-1:0]           rsp_beat_o,
    output logic                          rsp_last_o,
    output logic                          mem_req_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_ready_i,
    input  logic                          mem_valid_i,
    input  logic [WORD_WIDTH-1:0]         mem_data_i,
    output logic                          busy_o
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((1 << (OFF_BITS + 2)) - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [OFF_BITS-1:0]   beat_reg, beat_next;
    logic [OWN_W-1:0]      owner_reg, owner_next;
    logic [OWN_W-1:0]      last_owner_reg, last_owner_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [OWN_W:0]        rot_amt;
    logic [NUM_REQ-1:0]    req_rot;
    logic [NUM_REQ-1:0]    below;
    logic [NUM_REQ-1:0]    first_oh;
    logic [OWN_W-1:0]      off_acc [NUM_REQ+1];
    logic [OWN_W:0]        win_sum;
    logic [OWN_W-1:0]      win_idx;
    logic                  any_req;

    logic                  issue_st;
    logic                  busy_st;
    logic                  rsp_fire;
    logic                  last_beat;

    // Rotate requests so bit 0 is the requester just after the previous owner,
    // then pick the lowest set bit and rotate the offset back.
    assign rot_amt  = {1'b0, last_owner_reg} + (OWN_W + 1)'(1);
    assign req_rot  = NUM_REQ'({req_i, req_i} >> rot_amt);
    assign below[0] = 1'b0;
    assign off_acc[0] = '0;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_addr[gi]    = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign first_oh[gi]    = req_rot[gi] & ~below[gi];
        assign off_acc[gi+1]   = off_acc[gi] | (first_oh[gi] ? OWN_W'(gi) : '0);
        assign gnt_o[gi]       = busy_st && (owner_reg == OWN_W'(gi));
        assign rsp_valid_o[gi] = rsp_fire && (owner_reg == OWN_W'(gi));
        if (gi < NUM_REQ - 1) begin : g_below
            assign below[gi+1] = below[gi] | req_rot[gi];
        end
    end

    assign any_req = |req_i;
    assign win_sum = {1'b0, off_acc[NUM_REQ]} + rot_amt;
    assign win_idx = (win_sum >= (OWN_W + 1)'(NUM_REQ)) ?
                     OWN_W'(win_sum - (OWN_W + 1)'(NUM_REQ)) : win_sum[OWN_W-1:0];

    assign issue_st  = (state_reg == ST_ISSUE);
    assign busy_st   = (state_reg != ST_IDLE);
    assign last_beat = (beat_reg == OFF_BITS'(WORDS_PER_LINE - 1));
    // Data is forwarded combinationally in the cycle it arrives; stray beats outside WAIT are dropped.
    assign rsp_fire  = (state_reg == ST_WAIT) && mem_valid_i;

    assign busy_o     = busy_st;
    assign mem_req_o  = issue_st;
    assign mem_addr_o = issue_st ? (base_reg | ADDR_WIDTH'({beat_reg, 2'b00})) : '0;
    assign rsp_data_o = rsp_fire ? mem_data_i : '0;
    assign rsp_beat_o = rsp_fire ? beat_reg : '0;
    assign rsp_last_o = rsp_fire && last_beat;

    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        base_next       = base_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ISSUE;
                    owner_next = win_idx;
                    base_next  = req_addr[win_idx] & ~LINE_MASK;
                    beat_next  = '0;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_valid_i) begin
                    if (last_beat) begin
                        state_next      = ST_IDLE;
                        last_owner_next = owner_reg;
                        beat_next       = '0;
                    end else begin
                        state_next = ST_ISSUE;
                        beat_next  = beat_reg + OFF_BITS'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            owner_reg      <= '0;
            last_owner_reg <= OWN_W'(NUM_REQ - 1);
            base_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            base_reg       <= base_next;
        end
    end

endmodule
